// File: rtl/mips_mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mips_mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {IDLE, RD_WAIT} arb_state_e;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

endpackage

// File: rtl/mips_arb_starve_ctr.sv
// Saturating count of denied fetch cycles; raises prio when the limit is reached.
module mips_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req,
    input  logic gnt,
    output logic prio
);

    localparam logic [3:0] CntMax = 4'(STARVE_MAX);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt) begin
            cnt_d = 4'd0;
        end else if (req && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign prio = (cnt_q == CntMax);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory with fixed read latency.
// Optional stall counters are compiled in when MIPS_MEM_ARB_PERF_EN is defined.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MIPS_MEM_ARB_PERF_EN
    output logic [15:0]       if_stall_cnt,
    output logic [15:0]       d_stall_cnt,
`endif
    output logic              busy
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic [2:0] lat_q, lat_d;
    logic       last_cycle;
    logic       grantable;
    logic       fetch_prio;
    logic       rd_gnt;

    mips_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clock  (clock),
        .reset_n(reset_n),
        .req    (if_req),
        .gnt    (if_gnt),
        .prio   (fetch_prio)
    );

    // The rvalid cycle of a read doubles as a grant slot so reads can stream.
    assign last_cycle = (state_q == RD_WAIT) && (lat_q == 3'd1);
    assign grantable  = reset_n && ((state_q == IDLE) || last_cycle);

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grantable) begin
            if (if_req && (fetch_prio || !d_req)) begin
                if_gnt   = 1'b1;
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end else if (d_req) begin
                d_gnt    = 1'b1;
                mem_en   = 1'b1;
                mem_we   = d_we;
                mem_addr = d_addr;
                if (d_we) begin
                    mem_wdata = d_wdata;
                end
            end
        end
    end

    assign rd_gnt = if_gnt || (d_gnt && !d_we);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        owner_d = owner_q;
        if (rd_gnt) begin
            state_d = RD_WAIT;
            lat_d   = 3'(RD_LAT);
            owner_d = if_gnt ? OWN_IF : OWN_D;
        end else if (state_q == RD_WAIT) begin
            if (last_cycle) begin
                state_d = IDLE;
            end else begin
                lat_d = lat_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lat_q   <= 3'd0;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            owner_q <= owner_d;
        end
    end

    assign if_rvalid = reset_n && last_cycle && (owner_q == OWN_IF);
    assign d_rvalid  = reset_n && last_cycle && (owner_q == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign busy      = (state_q == RD_WAIT);

`ifdef MIPS_MEM_ARB_PERF_EN
    logic [15:0] if_stall_q, d_stall_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            if_stall_q <= 16'd0;
            d_stall_q  <= 16'd0;
        end else begin
            if (if_req && !if_gnt && (if_stall_q != 16'hFFFF)) begin
                if_stall_q <= if_stall_q + 16'd1;
            end
            if (d_req && !d_gnt && (d_stall_q != 16'hFFFF)) begin
                d_stall_q <= d_stall_q + 16'd1;
            end
        end
    end

    assign if_stall_cnt = if_stall_q;
    assign d_stall_cnt  = d_stall_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench: three arbiter instances (RD_LAT 1/2/3) share one stimulus set.
module tb_mips_mem_arbiter;

    localparam int L1 = 0;  // RD_LAT=1, STARVE_MAX=4
    localparam int L2 = 1;  // RD_LAT=2, STARVE_MAX=4
    localparam int L3 = 2;  // RD_LAT=3, STARVE_MAX=15

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [9:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;

    logic        if_gnt    [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata  [3];
    logic        d_gnt     [3];
    logic        d_rvalid  [3];
    logic [31:0] d_rdata   [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [9:0]  mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic        busy      [3];
`ifdef MIPS_MEM_ARB_PERF_EN
    logic [15:0] if_stall_cnt [3];
    logic [15:0] d_stall_cnt  [3];
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mips_mem_arbiter #(
            .ADDR_W    (10),
            .DATA_W    (32),
            .RD_LAT    (g + 1),
            .STARVE_MAX((g == 2) ? 15 : 4)
        ) u_dut (
            .clock    (clock),
            .reset_n  (reset_n),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_gnt   (if_gnt[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt[g]),
            .d_rvalid (d_rvalid[g]),
            .d_rdata  (d_rdata[g]),
            .mem_en   (mem_en[g]),
            .mem_we   (mem_we[g]),
            .mem_addr (mem_addr[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata),
`ifdef MIPS_MEM_ARB_PERF_EN
            .if_stall_cnt(if_stall_cnt[g]),
            .d_stall_cnt (d_stall_cnt[g]),
`endif
            .busy     (busy[g])
        );
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        if_req    = 1'b0;
        if_addr   = 10'h000;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 10'h000;
        d_wdata   = 32'h0;
        mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        if_req = 1'b1;
        d_req  = 1'b1;
        tick();
        settle();
        for (int g = 0; g < 3; g++) begin
            tests_run++;
            if (if_gnt[g] !== 1'b0 || d_gnt[g] !== 1'b0 || mem_en[g] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_gnt[%0d]: if_gnt=%0b d_gnt=%0b mem_en=%0b want 0",
                         g, if_gnt[g], d_gnt[g], mem_en[g]);
            end
            tests_run++;
            if (busy[g] !== 1'b0 || if_rvalid[g] !== 1'b0 || d_rvalid[g] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_state[%0d]: busy=%0b if_rv=%0b d_rv=%0b want 0",
                         g, busy[g], if_rvalid[g], d_rvalid[g]);
            end
        end
        reset_n = 1'b1;
        clear_inputs();
        d_we = 1'b1;  // must be ignored while d_req is low
        settle();
        tests_run++;
        if (mem_en[L1] !== 1'b0 || mem_we[L1] !== 1'b0 || d_gnt[L1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_we_ignored: mem_en=%0b mem_we=%0b d_gnt=%0b want 0",
                     mem_en[L1], mem_we[L1], d_gnt[L1]);
        end
    endtask

    task automatic test_fetch_read();
        do_reset();
        if_req  = 1'b1;
        if_addr = 10'h005;
        settle();
        tests_run++;
        if (if_gnt[L2] !== 1'b1 || mem_en[L2] !== 1'b1 || mem_addr[L2] !== 10'h005
            || mem_we[L2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_grant: gnt=%0b en=%0b addr=%h we=%0b want 1 1 005 0",
                     if_gnt[L2], mem_en[L2], mem_addr[L2], mem_we[L2]);
        end
        tick();
        if_req = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 10'h008;
        settle();
        tests_run++;
        if (d_gnt[L2] !== 1'b0 || mem_en[L2] !== 1'b0 || busy[L2] !== 1'b1
            || if_rvalid[L2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_wait: d_gnt=%0b en=%0b busy=%0b if_rv=%0b want 0 0 1 0",
                     d_gnt[L2], mem_en[L2], busy[L2], if_rvalid[L2]);
        end
        tick();
        mem_rdata = 32'h2000_0001;
        settle();
        tests_run++;
        if (if_rvalid[L2] !== 1'b1 || if_rdata[L2] !== 32'h2000_0001) begin
            tests_failed++;
            $display("FAIL fetch_data: rvalid=%0b rdata=%h want 1 20000001",
                     if_rvalid[L2], if_rdata[L2]);
        end
        tests_run++;
        if (d_rvalid[L2] !== 1'b0 || d_rdata[L2] !== 32'h0 || d_gnt[L2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fetch_nonowner: d_rv=%0b d_rdata=%h d_gnt=%0b want 0 0 1",
                     d_rvalid[L2], d_rdata[L2], d_gnt[L2]);
        end
        tick();
        d_req = 1'b0;
        settle();
        tests_run++;
        if (if_rvalid[L2] !== 1'b0 || busy[L2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fetch_after: if_rv=%0b busy=%0b want 0 1", if_rvalid[L2], busy[L2]);
        end
    endtask

    task automatic test_simul_reads();
        do_reset();
        if_req  = 1'b1;
        if_addr = 10'h005;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h007;
        settle();
        tests_run++;
        if (d_gnt[L1] !== 1'b1 || if_gnt[L1] !== 1'b0 || mem_addr[L1] !== 10'h007) begin
            tests_failed++;
            $display("FAIL simul_t0: d_gnt=%0b if_gnt=%0b addr=%h want 1 0 007",
                     d_gnt[L1], if_gnt[L1], mem_addr[L1]);
        end
        tick();
        d_req     = 1'b0;
        mem_rdata = 32'hAAAA_0007;
        settle();
        tests_run++;
        if (d_rvalid[L1] !== 1'b1 || d_rdata[L1] !== 32'hAAAA_0007 || if_rdata[L1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL simul_t1_data: d_rv=%0b d_rdata=%h if_rdata=%h want 1 aaaa0007 0",
                     d_rvalid[L1], d_rdata[L1], if_rdata[L1]);
        end
        tests_run++;
        if (if_gnt[L1] !== 1'b1 || mem_addr[L1] !== 10'h005 || if_rvalid[L1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_t1_gnt: if_gnt=%0b addr=%h if_rv=%0b want 1 005 0",
                     if_gnt[L1], mem_addr[L1], if_rvalid[L1]);
        end
        tick();
        if_req    = 1'b0;
        mem_rdata = 32'h5555_0005;
        settle();
        tests_run++;
        if (if_rvalid[L1] !== 1'b1 || if_rdata[L1] !== 32'h5555_0005 || d_rvalid[L1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_t2: if_rv=%0b if_rdata=%h d_rv=%0b want 1 55550005 0",
                     if_rvalid[L1], if_rdata[L1], d_rvalid[L1]);
        end
        tick();
        settle();
        tests_run++;
        if (busy[L1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_idle: busy=%0b want 0", busy[L1]);
        end
    endtask

    task automatic test_starvation();
        logic exp_d, exp_i;
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h100;
        d_wdata = 32'h1234_5678;
        if_req  = 1'b1;
        if_addr = 10'h001;
        for (int c = 1; c <= 6; c++) begin
            settle();
            exp_d = (c != 5);
            exp_i = (c == 5);
            tests_run++;
            if (d_gnt[L1] !== exp_d || if_gnt[L1] !== exp_i) begin
                tests_failed++;
                $display("FAIL starve_c%0d: d_gnt=%0b if_gnt=%0b want %0b %0b",
                         c, d_gnt[L1], if_gnt[L1], exp_d, exp_i);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_write();
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h3FF;
        d_wdata = 32'hDEAD_BEEF;
        settle();
        tests_run++;
        if (d_gnt[L1] !== 1'b1 || mem_en[L1] !== 1'b1 || mem_we[L1] !== 1'b1
            || mem_addr[L1] !== 10'h3FF || mem_wdata[L1] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL write_grant: gnt=%0b en=%0b we=%0b addr=%h wdata=%h want 1 1 1 3ff deadbeef",
                     d_gnt[L1], mem_en[L1], mem_we[L1], mem_addr[L1], mem_wdata[L1]);
        end
        tick();
        d_we   = 1'b0;
        d_addr = 10'h010;
        settle();
        tests_run++;
        if (d_rvalid[L1] !== 1'b0 || busy[L1] !== 1'b0 || d_gnt[L1] !== 1'b1
            || mem_we[L1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_then_read: d_rv=%0b busy=%0b d_gnt=%0b we=%0b want 0 0 1 0",
                     d_rvalid[L1], busy[L1], d_gnt[L1], mem_we[L1]);
        end
        tick();
        d_req     = 1'b0;
        mem_rdata = 32'h0000_0010;
        settle();
        tests_run++;
        if (d_rvalid[L1] !== 1'b1 || d_rdata[L1] !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL write_read_data: d_rv=%0b d_rdata=%h want 1 00000010",
                     d_rvalid[L1], d_rdata[L1]);
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        if_req  = 1'b1;
        if_addr = 10'h005;
        settle();
        tests_run++;
        if (if_gnt[L3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_grant: if_gnt=%0b want 1", if_gnt[L3]);
        end
        tick();
        if_req  = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 10'h009;
        settle();
        tests_run++;
        if (busy[L3] !== 1'b0 || d_gnt[L3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_after: busy=%0b d_gnt=%0b want 0 1", busy[L3], d_gnt[L3]);
        end
        tick();
        d_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            settle();
            tests_run++;
            if (if_rvalid[L3] !== 1'b0 || d_rvalid[L3] !== (c == 3)) begin
                tests_failed++;
                $display("FAIL midrst_c%0d: if_rv=%0b d_rv=%0b want 0 %0b",
                         c, if_rvalid[L3], d_rvalid[L3], (c == 3));
            end
            tick();
        end
    endtask

`ifdef MIPS_MEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h020;
        d_wdata = 32'hCAFE_F00D;
        if_req  = 1'b1;
        if_addr = 10'h002;
        repeat (10) tick();
        settle();
        tests_run++;
        if (if_stall_cnt[L3] !== 16'd10 || d_stall_cnt[L3] !== 16'd0) begin
            tests_failed++;
            $display("FAIL perf_count: if_stall=%0d d_stall=%0d want 10 0",
                     if_stall_cnt[L3], d_stall_cnt[L3]);
        end
        force g_dut[2].u_dut.if_stall_q = 16'hFFFF;
        tick();
        release g_dut[2].u_dut.if_stall_q;
        tick();
        tick();
        settle();
        tests_run++;
        if (if_stall_cnt[L3] !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL perf_saturate: if_stall=%h want ffff", if_stall_cnt[L3]);
        end
        clear_inputs();
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_fetch_read();
        test_simul_reads();
        test_starvation();
        test_write();
        test_reset_mid_read();
`ifdef MIPS_MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
